// File: rtl/pre_mac_route_tagger.sv
// pre_mac_route_tagger
//
// Ingress stage that sits between the per-VM egress streams and the shared
// MAC. Each packet is tagged on tuser with a route mask. The mask comes from a
// runtime-programmable table indexed by the packet's source tid. It is looked
// up on the first beat of the packet and held for every later beat. Packets
// whose mask is all-zero are consumed and discarded. The output is a
// registered 2-entry skid buffer. Forwarded and dropped packets are counted
// when their tlast beat is accepted.
//
// Ports
//   aclk, aresetn            clock, synchronous active-low reset
//   axis_in_*                upstream AXI-Stream slave (tdata/tid/tdest/tkeep/tlast/tvalid/tready)
//   axis_out_*               downstream AXI-Stream master, same fields plus tuser (route mask)
//   cfg_wr_en/id/mask        route-table write port
//   pkt_fwd_count            packets forwarded
//   pkt_drop_count           packets dropped
module pre_mac_route_tagger #(
    parameter int AXIS_BUS_WIDTH  = 64,
    parameter int AXIS_ID_WIDTH   = 4,
    parameter int AXIS_DEST_WIDTH = 0,
    parameter int LOOPBACK_EN     = 0,
    parameter int CNT_WIDTH       = 32,
    localparam int NUM_AXIS_ID    = 2 ** AXIS_ID_WIDTH,
    localparam int ID_PW          = (AXIS_ID_WIDTH > 0) ? AXIS_ID_WIDTH : 1,
    localparam int DEST_PW        = (AXIS_DEST_WIDTH > 0) ? AXIS_DEST_WIDTH : 1,
    localparam int KEEP_W         = AXIS_BUS_WIDTH / 8
) (
    input  logic                      aclk,
    input  logic                      aresetn,

    input  logic [AXIS_BUS_WIDTH-1:0] axis_in_tdata,
    input  logic [ID_PW-1:0]          axis_in_tid,
    input  logic [DEST_PW-1:0]        axis_in_tdest,
    input  logic [KEEP_W-1:0]         axis_in_tkeep,
    input  logic                      axis_in_tlast,
    input  logic                      axis_in_tvalid,
    output logic                      axis_in_tready,

    output logic [AXIS_BUS_WIDTH-1:0] axis_out_tdata,
    output logic [ID_PW-1:0]          axis_out_tid,
    output logic [DEST_PW-1:0]        axis_out_tdest,
    output logic [KEEP_W-1:0]         axis_out_tkeep,
    output logic                      axis_out_tlast,
    output logic [NUM_AXIS_ID-1:0]    axis_out_tuser,
    output logic                      axis_out_tvalid,
    input  logic                      axis_out_tready,

    input  logic                      cfg_wr_en,
    input  logic [ID_PW-1:0]          cfg_wr_id,
    input  logic [NUM_AXIS_ID-1:0]    cfg_wr_mask,

    output logic [CNT_WIDTH-1:0]      pkt_fwd_count,
    output logic [CNT_WIDTH-1:0]      pkt_drop_count
);

    localparam logic [NUM_AXIS_ID-1:0] MASK_ONE = NUM_AXIS_ID'(1);

    typedef struct packed {
        logic [AXIS_BUS_WIDTH-1:0] tdata;
        logic [ID_PW-1:0]          tid;
        logic [DEST_PW-1:0]        tdest;
        logic [KEEP_W-1:0]         tkeep;
        logic                      tlast;
        logic [NUM_AXIS_ID-1:0]    tuser;
    } beat_t;

    logic [NUM_AXIS_ID-1:0] route_table [NUM_AXIS_ID];

    logic                   sop_flag;
    logic                   pkt_drop;
    logic [NUM_AXIS_ID-1:0] pkt_mask;

    logic [NUM_AXIS_ID-1:0] lookup_mask;
    logic [NUM_AXIS_ID-1:0] beat_mask;
    logic                   beat_drop;
    logic                   accept;
    logic                   push;
    logic                   out_free;
    beat_t                  in_beat;

    beat_t                  out_reg;
    beat_t                  skid_reg;
    logic                   out_valid;
    logic                   skid_valid;

    // Route lookup. The table read is combinational on the registered table,
    // so a write landing in the same cycle is seen only from the next cycle.
    // Without loopback a source never routes back to itself.
    always_comb begin
        lookup_mask = route_table[axis_in_tid];
        if (LOOPBACK_EN == 0) begin
            lookup_mask = lookup_mask & ~(MASK_ONE << axis_in_tid);
        end
        beat_mask = sop_flag ? lookup_mask : pkt_mask;
        beat_drop = sop_flag ? (lookup_mask == '0) : pkt_drop;
    end

    // Ready depends only on the skid register, so a beat can always be taken
    // into the skid while the output register is stalled.
    assign axis_in_tready = aresetn & ~skid_valid;
    assign accept         = axis_in_tvalid & axis_in_tready;
    assign push           = accept & ~beat_drop;
    assign out_free       = ~out_valid | axis_out_tready;

    always_comb begin
        in_beat.tdata = axis_in_tdata;
        in_beat.tid   = axis_in_tid;
        in_beat.tdest = axis_in_tdest;
        in_beat.tkeep = axis_in_tkeep;
        in_beat.tlast = axis_in_tlast;
        in_beat.tuser = beat_mask;
    end

    // Route table, all-ones after reset so every source broadcasts by default.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_AXIS_ID; i++) begin
                route_table[i] <= '1;
            end
        end else if (cfg_wr_en) begin
            route_table[cfg_wr_id] <= cfg_wr_mask;
        end
    end

    // Per-packet state. Non-SOP beats reload the held values unchanged, so
    // latching on every accepted beat keeps the SOP mask for the whole packet.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            sop_flag <= 1'b1;
            pkt_mask <= '0;
            pkt_drop <= 1'b0;
        end else if (accept) begin
            sop_flag <= axis_in_tlast;
            pkt_mask <= beat_mask;
            pkt_drop <= beat_drop;
        end
    end

    // Packet counters, counted at input acceptance of the tlast beat.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            pkt_fwd_count  <= '0;
            pkt_drop_count <= '0;
        end else if (accept && axis_in_tlast) begin
            if (beat_drop) begin
                pkt_drop_count <= pkt_drop_count + CNT_WIDTH'(1);
            end else begin
                pkt_fwd_count <= pkt_fwd_count + CNT_WIDTH'(1);
            end
        end
    end

    // Two-entry skid buffer. When the output register can advance it takes
    // the skid beat first (preserving order), otherwise the incoming beat.
    // A push while the output is stalled parks in the skid register; ready is
    // low whenever the skid is occupied, so push and full skid never coincide.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            out_reg    <= '0;
            skid_reg   <= '0;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_reg    <= skid_reg;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                if (push) begin
                    out_reg <= in_beat;
                end
                out_valid <= push;
            end
        end else if (push) begin
            skid_reg   <= in_beat;
            skid_valid <= 1'b1;
        end
    end

    assign axis_out_tdata  = out_reg.tdata;
    assign axis_out_tid    = out_reg.tid;
    assign axis_out_tdest  = out_reg.tdest;
    assign axis_out_tkeep  = out_reg.tkeep;
    assign axis_out_tlast  = out_reg.tlast;
    assign axis_out_tuser  = out_reg.tuser;
    assign axis_out_tvalid = out_valid;

endmodule

// File: tb/tb_pre_mac_route_tagger.sv
// tb_pre_mac_route_tagger
//
// Bench for pre_mac_route_tagger with default parameters (64-bit data,
// 16 sources, no loopback). Drivers push the expected output beats onto a
// scoreboard queue as they are accepted; a monitor pops and compares each
// beat transferred on the output and checks that stalled outputs stay stable.
module tb_pre_mac_route_tagger;

    typedef struct packed {
        logic [63:0] data;
        logic [3:0]  tid;
        logic        dest;
        logic [7:0]  keep;
        logic        last;
        logic [15:0] user;
    } beat_t;

    logic        aclk;
    logic        aresetn;
    logic [63:0] axis_in_tdata;
    logic [3:0]  axis_in_tid;
    logic [0:0]  axis_in_tdest;
    logic [7:0]  axis_in_tkeep;
    logic        axis_in_tlast;
    logic        axis_in_tvalid;
    logic        axis_in_tready;
    logic [63:0] axis_out_tdata;
    logic [3:0]  axis_out_tid;
    logic [0:0]  axis_out_tdest;
    logic [7:0]  axis_out_tkeep;
    logic        axis_out_tlast;
    logic [15:0] axis_out_tuser;
    logic        axis_out_tvalid;
    logic        axis_out_tready;
    logic        cfg_wr_en;
    logic [3:0]  cfg_wr_id;
    logic [15:0] cfg_wr_mask;
    logic [31:0] pkt_fwd_count;
    logic [31:0] pkt_drop_count;

    beat_t       sb[$];
    int          checks;
    int          errors;
    int          in_stalls;
    int          rdy_mode;
    int          cyc;
    bit          b2b_watch;
    int          b2b_pops;
    int          gap_viol;
    int          last_pop_cyc;
    logic [63:0] last_data;

    pre_mac_route_tagger dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .axis_in_tdata   (axis_in_tdata),
        .axis_in_tid     (axis_in_tid),
        .axis_in_tdest   (axis_in_tdest),
        .axis_in_tkeep   (axis_in_tkeep),
        .axis_in_tlast   (axis_in_tlast),
        .axis_in_tvalid  (axis_in_tvalid),
        .axis_in_tready  (axis_in_tready),
        .axis_out_tdata  (axis_out_tdata),
        .axis_out_tid    (axis_out_tid),
        .axis_out_tdest  (axis_out_tdest),
        .axis_out_tkeep  (axis_out_tkeep),
        .axis_out_tlast  (axis_out_tlast),
        .axis_out_tuser  (axis_out_tuser),
        .axis_out_tvalid (axis_out_tvalid),
        .axis_out_tready (axis_out_tready),
        .cfg_wr_en       (cfg_wr_en),
        .cfg_wr_id       (cfg_wr_id),
        .cfg_wr_mask     (cfg_wr_mask),
        .pkt_fwd_count   (pkt_fwd_count),
        .pkt_drop_count  (pkt_drop_count)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge aclk);
            cyc = cyc + 1;
        end
    end

    // Downstream ready: 0 = always ready, 1 = toggle every cycle, 2 = held low.
    initial begin
        axis_out_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            case (rdy_mode)
                1:       axis_out_tready = ~axis_out_tready;
                2:       axis_out_tready = 1'b0;
                default: axis_out_tready = 1'b1;
            endcase
        end
    end

    // Output monitor: sampled mid-cycle, so valid&ready here means a transfer
    // at the coming rising edge.
    initial begin
        beat_t got;
        beat_t exp;
        beat_t prev;
        bit    prev_stalled;
        prev_stalled = 1'b0;
        prev = '0;
        forever begin
            @(negedge aclk);
            got = {axis_out_tdata, axis_out_tid, axis_out_tdest, axis_out_tkeep,
                   axis_out_tlast, axis_out_tuser};
            if (!aresetn) begin
                prev_stalled = 1'b0;
            end else begin
                if (prev_stalled) begin
                    checks = checks + 1;
                    if (axis_out_tvalid !== 1'b1 || got !== prev) begin
                        errors = errors + 1;
                        $display("[TB] FAIL stall_stable: valid=%b data=%h user=%h, required valid=1 data=%h user=%h",
                                 axis_out_tvalid, got.data, got.user, prev.data, prev.user);
                    end
                end
                if (axis_out_tvalid === 1'b1 && axis_out_tready === 1'b1) begin
                    checks = checks + 1;
                    if (sb.size() == 0) begin
                        errors = errors + 1;
                        $display("[TB] FAIL unexpected_beat: data=%h user=%h, required no beat",
                                 got.data, got.user);
                    end else begin
                        exp = sb.pop_front();
                        if (got !== exp) begin
                            errors = errors + 1;
                            $display("[TB] FAIL out_beat: data=%h tid=%h keep=%h last=%b user=%h, required data=%h tid=%h keep=%h last=%b user=%h",
                                     got.data, got.tid, got.keep, got.last, got.user,
                                     exp.data, exp.tid, exp.keep, exp.last, exp.user);
                        end
                    end
                    if (b2b_watch) begin
                        if (b2b_pops > 0 && cyc != last_pop_cyc + 1) begin
                            gap_viol = gap_viol + 1;
                        end
                        last_pop_cyc = cyc;
                        b2b_pops = b2b_pops + 1;
                    end
                end
                prev_stalled = (axis_out_tvalid === 1'b1) && (axis_out_tready === 1'b0);
                prev = got;
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Drives one beat and holds it until accepted; leaves the bench 1 time
    // unit after the accepting edge with tvalid still high.
    task automatic drive_beat(input logic [3:0] tid, input logic last,
                              input logic [15:0] user, input bit drop);
        beat_t b;
        bit    done;
        b.data = {$urandom, $urandom};
        b.tid  = tid;
        b.dest = 1'($urandom);
        b.keep = 8'($urandom);
        b.last = last;
        b.user = user;
        axis_in_tdata  = b.data;
        axis_in_tid    = b.tid;
        axis_in_tdest  = b.dest;
        axis_in_tkeep  = b.keep;
        axis_in_tlast  = b.last;
        axis_in_tvalid = 1'b1;
        last_data      = b.data;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge aclk);
            if (axis_in_tready === 1'b1) begin
                if (!drop) sb.push_back(b);
                done = 1'b1;
            end else begin
                in_stalls = in_stalls + 1;
            end
            @(posedge aclk);
            #1;
        end
        if (!done) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("[TB] FAIL in_accept_timeout: tready=%b for 100 cycles, required 1", axis_in_tready);
        end
    endtask

    task automatic idle_input();
        axis_in_tvalid = 1'b0;
        axis_in_tlast  = 1'b0;
    endtask

    task automatic send_packet(input int n, input logic [3:0] tid,
                               input logic [15:0] user, input bit drop);
        for (int i = 0; i < n; i++) begin
            drive_beat(tid, (i == n - 1), user, drop);
        end
        idle_input();
    endtask

    task automatic cfg_write(input logic [3:0] id, input logic [15:0] mask);
        cfg_wr_id   = id;
        cfg_wr_mask = mask;
        cfg_wr_en   = 1'b1;
        @(posedge aclk);
        #1;
        cfg_wr_en   = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int c;
        c = 0;
        while (sb.size() != 0 && c < 300) begin
            @(posedge aclk);
            c++;
        end
        repeat (6) @(posedge aclk);
        #1;
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("[TB] FAIL %s_drain: %0d beats outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_counts(input string name, input int fwd, input int drp);
        checks = checks + 1;
        if (pkt_fwd_count !== 32'(fwd) || pkt_drop_count !== 32'(drp)) begin
            errors = errors + 1;
            $display("[TB] FAIL %s_counts: fwd=%0d drop=%0d, required fwd=%0d drop=%0d",
                     name, pkt_fwd_count, pkt_drop_count, fwd, drp);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checks = checks + 1;
        if (axis_out_tvalid !== 1'b0 || axis_in_tready !== 1'b0 ||
            axis_out_tdata !== 64'h0 || axis_out_tuser !== 16'h0 || axis_out_tlast !== 1'b0) begin
            errors = errors + 1;
            $display("[TB] FAIL reset_outputs: out_valid=%b in_ready=%b data=%h user=%h last=%b, required 0 0 0 0 0",
                     axis_out_tvalid, axis_in_tready, axis_out_tdata, axis_out_tuser, axis_out_tlast);
        end
        check_counts("reset", 0, 0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(negedge aclk);
        checks = checks + 1;
        if (axis_in_tready !== 1'b1 || axis_out_tvalid !== 1'b0) begin
            errors = errors + 1;
            $display("[TB] FAIL reset_release: in_ready=%b out_valid=%b, required 1 0",
                     axis_in_tready, axis_out_tvalid);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic test_basic();
        drive_beat(4'd3, 1'b0, 16'hFFF7, 1'b0);
        checks = checks + 1;
        if (axis_out_tvalid !== 1'b1 || axis_out_tdata !== last_data || axis_out_tuser !== 16'hFFF7) begin
            errors = errors + 1;
            $display("[TB] FAIL basic_latency: valid=%b data=%h user=%h, required 1 %h FFF7",
                     axis_out_tvalid, axis_out_tdata, axis_out_tuser, last_data);
        end
        drive_beat(4'd3, 1'b0, 16'hFFF7, 1'b0);
        drive_beat(4'd3, 1'b1, 16'hFFF7, 1'b0);
        idle_input();
        wait_drain("basic");
        check_counts("basic", 1, 0);
    endtask

    task automatic test_drop();
        cfg_write(4'd2, 16'h0004);
        in_stalls = 0;
        send_packet(2, 4'd2, 16'h0000, 1'b1);
        wait_drain("drop");
        checks = checks + 1;
        if (in_stalls != 0) begin
            errors = errors + 1;
            $display("[TB] FAIL drop_ready: %0d stall cycles, required 0", in_stalls);
        end
        check_counts("drop", 1, 1);
    endtask

    task automatic test_write_collision();
        in_stalls = 0;
        cfg_wr_id   = 4'd1;
        cfg_wr_mask = 16'h00F0;
        cfg_wr_en   = 1'b1;
        drive_beat(4'd1, 1'b0, 16'hFFFD, 1'b0);
        cfg_wr_en   = 1'b0;
        drive_beat(4'd1, 1'b1, 16'hFFFD, 1'b0);
        idle_input();
        checks = checks + 1;
        if (in_stalls != 0) begin
            errors = errors + 1;
            $display("[TB] FAIL collision_same_cycle: %0d stall cycles, required 0", in_stalls);
        end
        send_packet(2, 4'd1, 16'h00F0, 1'b0);
        wait_drain("collision");
        check_counts("collision", 3, 1);
    endtask

    task automatic test_stall_toggle();
        rdy_mode = 1;
        send_packet(8, 4'd0, 16'hFFFE, 1'b0);
        wait_drain("toggle");
        rdy_mode = 0;
        @(posedge aclk);
        #1;
        check_counts("toggle", 4, 1);
    endtask

    task automatic test_reset_mid_packet();
        rdy_mode = 2;
        @(posedge aclk);
        #1;
        drive_beat(4'd4, 1'b0, 16'hFFEF, 1'b0);
        drive_beat(4'd4, 1'b0, 16'hFFEF, 1'b0);
        idle_input();
        aresetn = 1'b0;
        @(negedge aclk);
        checks = checks + 1;
        if (axis_in_tready !== 1'b0) begin
            errors = errors + 1;
            $display("[TB] FAIL midrst_ready: in_ready=%b during reset, required 0", axis_in_tready);
        end
        @(posedge aclk);
        #1;
        aresetn  = 1'b1;
        rdy_mode = 0;
        sb.delete();
        @(negedge aclk);
        checks = checks + 1;
        if (axis_out_tvalid !== 1'b0) begin
            errors = errors + 1;
            $display("[TB] FAIL midrst_flush: out_valid=%b, required 0", axis_out_tvalid);
        end
        check_counts("midrst", 0, 0);
        @(posedge aclk);
        #1;
        send_packet(1, 4'd5, 16'hFFDF, 1'b0);
        wait_drain("midrst");
        check_counts("midrst_after", 1, 0);
    endtask

    task automatic test_back_to_back();
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        sb.delete();
        in_stalls = 0;
        b2b_pops  = 0;
        gap_viol  = 0;
        b2b_watch = 1'b1;
        for (int n = 0; n < 16; n++) begin
            drive_beat(4'(n), 1'b1, 16'hFFFF ^ (16'h0001 << n), 1'b0);
        end
        idle_input();
        wait_drain("b2b");
        b2b_watch = 1'b0;
        checks = checks + 1;
        if (b2b_pops != 16 || gap_viol != 0 || in_stalls != 0) begin
            errors = errors + 1;
            $display("[TB] FAIL b2b_throughput: beats=%0d gaps=%0d stalls=%0d, required 16 0 0",
                     b2b_pops, gap_viol, in_stalls);
        end
        check_counts("b2b", 16, 0);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        in_stalls      = 0;
        rdy_mode       = 0;
        b2b_watch      = 1'b0;
        b2b_pops       = 0;
        gap_viol       = 0;
        last_pop_cyc   = 0;
        last_data      = '0;
        aresetn        = 1'b0;
        axis_in_tdata  = '0;
        axis_in_tid    = '0;
        axis_in_tdest  = '0;
        axis_in_tkeep  = '0;
        axis_in_tlast  = 1'b0;
        axis_in_tvalid = 1'b0;
        cfg_wr_en      = 1'b0;
        cfg_wr_id      = '0;
        cfg_wr_mask    = '0;

        test_reset();
        test_basic();
        test_drop();
        test_write_collision();
        test_stall_toggle();
        test_reset_mid_packet();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
